// File: rtl/traffic_countdown_pkg.sv
// traffic_pkg: shared phase encoding, counter width and duration helpers for
// the traffic_countdown block and the segment_display decoder.
package traffic_pkg;

    // Counter width shared with segment_display.
    localparam int CNT_W = 6;

    // Largest phase duration the 6-bit counter can hold.
    localparam int MAX_DURATION = 63;

    // Phase encoding; 2'b11 is illegal and recovers to RED.
    typedef enum logic [1:0] {
        PHASE_RED    = 2'b00,
        PHASE_GREEN  = 2'b01,
        PHASE_YELLOW = 2'b10
    } phase_t;

    // Plain constants for the FSM register, which is kept as raw bits so the
    // illegal code can be observed and recovered.
    localparam logic [1:0] ST_RED    = PHASE_RED;
    localparam logic [1:0] ST_GREEN  = PHASE_GREEN;
    localparam logic [1:0] ST_YELLOW = PHASE_YELLOW;

    // A configured duration of 0 is promoted to 1 so a phase always lasts at
    // least one tick and the counter never has to show 0.
    function automatic logic [CNT_W-1:0] sanitize_duration(input int unsigned dur);
        logic [CNT_W-1:0] val_s;
        if (dur == 32'd0) begin
            val_s = 6'd1;
        end else begin
            val_s = CNT_W'(dur);
        end
        return val_s;
    endfunction

    // Fixed phase order RED -> GREEN -> YELLOW -> RED; anything else goes RED.
    function automatic logic [1:0] next_phase(input logic [1:0] st);
        logic [1:0] nxt_s;
        case (st)
            ST_RED:    nxt_s = ST_GREEN;
            ST_GREEN:  nxt_s = ST_YELLOW;
            ST_YELLOW: nxt_s = ST_RED;
            default:   nxt_s = ST_RED;
        endcase
        return nxt_s;
    endfunction

endpackage

// File: rtl/traffic_countdown_core.sv
// countdown_core: loadable down-counter holding the remaining seconds of the
// current phase. Load has priority over decrement; the counter never goes
// below 1 on its own.
module countdown_core
    import traffic_pkg::*;
#(
    parameter logic [CNT_W-1:0] RESET_VAL = 6'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count_value,
    output logic             at_one
);

    logic [CNT_W-1:0] count_r;

    // Counter register: reset value, then load, then guarded decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= RESET_VAL;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r > 6'd1)) begin
            count_r <= count_r - 6'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign count_value = count_r;
    assign at_one      = (count_r == 6'd1);

endmodule

// File: rtl/traffic_countdown.sv
// traffic_countdown: RED -> GREEN -> YELLOW phase sequencer with a seconds
// countdown, one-hot lamp outputs and a phase-change strobe.
// Optional feature macro: TRAFFIC_PED_REQ_EN (pedestrian request shortens GREEN).
module traffic_countdown
    import traffic_pkg::*;
#(
    parameter int unsigned RED_TIME      = 15,
    parameter int unsigned GREEN_TIME    = 20,
    parameter int unsigned YELLOW_TIME   = 3,
    parameter int unsigned PED_GREEN_MAX = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             run,
`ifdef TRAFFIC_PED_REQ_EN
    input  logic             ped_req,
`endif
    output logic [CNT_W-1:0] count_value,
    output logic             light_red,
    output logic             light_green,
    output logic             light_yellow,
    output logic             phase_done
);

    // Durations wider than the counter are a configuration error.
    if ((RED_TIME > MAX_DURATION) || (GREEN_TIME > MAX_DURATION) ||
        (YELLOW_TIME > MAX_DURATION) || (PED_GREEN_MAX > MAX_DURATION)) begin : g_cfg_error
        $error("traffic_countdown: a duration parameter exceeds 63");
    end

    localparam logic [CNT_W-1:0] RED_DUR    = sanitize_duration(RED_TIME);
    localparam logic [CNT_W-1:0] GREEN_DUR  = sanitize_duration(GREEN_TIME);
    localparam logic [CNT_W-1:0] YELLOW_DUR = sanitize_duration(YELLOW_TIME);
    localparam logic [CNT_W-1:0] PED_MAX    = sanitize_duration(PED_GREEN_MAX);

    // Duration loaded on entry to a given phase.
    function automatic logic [CNT_W-1:0] duration_of(input logic [1:0] st);
        logic [CNT_W-1:0] dur_s;
        case (st)
            ST_RED:    dur_s = RED_DUR;
            ST_GREEN:  dur_s = GREEN_DUR;
            ST_YELLOW: dur_s = YELLOW_DUR;
            default:   dur_s = RED_DUR;
        endcase
        return dur_s;
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       next_state_s;
    logic             advance_s;
    logic             at_one_s;
    logic             load_s;
    logic             dec_s;
    logic [CNT_W-1:0] load_val_s;
    logic             done_next_s;
    logic             enter_red_s;
    logic             clamp_s;
    logic             light_red_r;
    logic             light_green_r;
    logic             light_yellow_r;
    logic             phase_done_r;

    // A tick only counts while the timer is running; ticks during a hold are
    // dropped rather than queued.
    assign advance_s = tick & run;

`ifdef TRAFFIC_PED_REQ_EN
    logic ped_latch_r;

    // Shorten GREEN only while the remaining time is above the ceiling.
    assign clamp_s = (state_r == ST_GREEN) && ped_latch_r && (count_value > PED_MAX);

    // Sticky pedestrian latch; RED entry wins over a same-edge request, and a
    // frozen timer freezes the latch too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_latch_r <= 1'b0;
        end else if (enter_red_s) begin
            ped_latch_r <= 1'b0;
        end else if (run && ped_req) begin
            ped_latch_r <= 1'b1;
        end else begin
            ped_latch_r <= ped_latch_r;
        end
    end
`else
    assign clamp_s = 1'b0;
`endif

    // Phase sequencing and counter control for the next edge.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        load_val_s   = count_value;
        dec_s        = 1'b0;
        done_next_s  = 1'b0;
        case (state_r)
            ST_RED, ST_GREEN, ST_YELLOW: begin
                if (advance_s) begin
                    if (at_one_s) begin
                        next_state_s = next_phase(state_r);
                        load_s       = 1'b1;
                        load_val_s   = duration_of(next_phase(state_r));
                        done_next_s  = 1'b1;
                    end else if (clamp_s) begin
                        load_s     = 1'b1;
                        load_val_s = PED_MAX;
                    end else begin
                        dec_s = 1'b1;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                // Illegal code: fall back to a clean RED phase.
                next_state_s = ST_RED;
                load_s       = 1'b1;
                load_val_s   = RED_DUR;
            end
        endcase
    end

    assign enter_red_s = (next_state_s == ST_RED) && (state_r != ST_RED);

    // State register plus registered lamp decode and phase-change strobe, so
    // the new lamp, new count and strobe all appear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_RED;
            light_red_r    <= 1'b1;
            light_green_r  <= 1'b0;
            light_yellow_r <= 1'b0;
            phase_done_r   <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            light_red_r    <= (next_state_s == ST_RED);
            light_green_r  <= (next_state_s == ST_GREEN);
            light_yellow_r <= (next_state_s == ST_YELLOW);
            phase_done_r   <= done_next_s;
        end
    end

    countdown_core #(
        .RESET_VAL (RED_DUR)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load_s),
        .load_val    (load_val_s),
        .dec         (dec_s),
        .count_value (count_value),
        .at_one      (at_one_s)
    );

    assign light_red    = light_red_r;
    assign light_green  = light_green_r;
    assign light_yellow = light_yellow_r;
    assign phase_done   = phase_done_r;

endmodule

// File: tb/tb_traffic_countdown.sv
// Self-checking bench for traffic_countdown: a directed vector table, a few
// hand-written multi-cycle sequences and randomized stimulus against a
// phase/remaining-seconds reference model.
module tb_traffic_countdown;

    localparam int RED_D   = 15;
    localparam int GREEN_D = 20;
    localparam int YEL_D   = 3;
    localparam int PED_MAX = 5;
    localparam int L_R = 4;
    localparam int L_G = 2;
    localparam int L_Y = 1;
`ifdef TRAFFIC_PED_REQ_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       run;
    logic       ped_req;
    logic [5:0] count_value;
    logic       light_red;
    logic       light_green;
    logic       light_yellow;
    logic       phase_done;

    always #5 clk = ~clk;

    traffic_countdown dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .run          (run),
`ifdef TRAFFIC_PED_REQ_EN
        .ped_req      (ped_req),
`endif
        .count_value  (count_value),
        .light_red    (light_red),
        .light_green  (light_green),
        .light_yellow (light_yellow),
        .phase_done   (phase_done)
    );

    typedef struct {
        logic tick;
        logic run;
        int   exp_count;
        int   exp_lamps;
        int   exp_done;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model state: phase index 0=RED,1=GREEN,2=YELLOW.
    int m_phase;
    int m_rem;
    int m_done;
    bit m_latch;
    int dur[3] = '{RED_D, GREEN_D, YEL_D};

    function automatic int lamps_of(input int ph);
        return (ph == 0) ? L_R : ((ph == 1) ? L_G : L_Y);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic check_out(input string tag, input int ecount, input int elamps, input int edone);
        check({tag, " count"}, int'(count_value), ecount);
        check({tag, " lamps"}, int'({light_red, light_green, light_yellow}), elamps);
        check({tag, " done"},  int'(phase_done), edone);
    endtask

    task automatic add_vec(input logic t, input logic r, input int c, input int l, input int d);
        vec_t v;
        v.tick = t; v.run = r; v.exp_count = c; v.exp_lamps = l; v.exp_done = d;
        vecs.push_back(v);
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, sample at
    // the next falling edge.
    task automatic apply(input logic t, input logic r, input logic p);
        tick = t; run = r; ped_req = p;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_phase = 0; m_rem = RED_D; m_done = 0; m_latch = 1'b0;
    endtask

    task automatic model_step(input logic t, input logic r, input logic p);
        bit enter_red;
        enter_red = 1'b0;
        m_done = 0;
        if (t && r) begin
            if (m_rem == 1) begin
                m_phase = (m_phase + 1) % 3;
                m_rem = dur[m_phase];
                m_done = 1;
                enter_red = (m_phase == 0);
            end else if (PED_EN && m_phase == 1 && m_latch && m_rem > PED_MAX) begin
                m_rem = PED_MAX;
            end else begin
                m_rem = m_rem - 1;
            end
        end
        if (enter_red) m_latch = 1'b0;
        else if (r && p && PED_EN) m_latch = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick = 1'b0; run = 1'b1; ped_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int done_pulses;
        rst_n = 1'b0; tick = 1'b0; run = 1'b1; ped_req = 1'b0;

        // Directed table: one full 38-tick cycle including a run hold.
        for (int i = 0; i < 3; i++) add_vec(1'b0, 1'b1, RED_D, L_R, 0);
        add_vec(1'b1, 1'b0, RED_D, L_R, 0);
        for (int k = 14; k >= 1; k--) add_vec(1'b1, 1'b1, k, L_R, 0);
        add_vec(1'b1, 1'b1, GREEN_D, L_G, 1);
        add_vec(1'b0, 1'b1, GREEN_D, L_G, 0);
        for (int k = 19; k >= 12; k--) add_vec(1'b1, 1'b1, k, L_G, 0);
        for (int i = 0; i < 5; i++) add_vec(1'b1, 1'b0, 12, L_G, 0);
        for (int k = 11; k >= 1; k--) add_vec(1'b1, 1'b1, k, L_G, 0);
        add_vec(1'b1, 1'b1, YEL_D, L_Y, 1);
        add_vec(1'b1, 1'b1, 2, L_Y, 0);
        add_vec(1'b1, 1'b1, 1, L_Y, 0);
        add_vec(1'b1, 1'b1, RED_D, L_R, 1);
        add_vec(1'b0, 1'b1, RED_D, L_R, 0);

        do_reset();
        check_out("reset", RED_D, L_R, 0);
        done_pulses = 0;
        foreach (vecs[i]) begin
            apply(vecs[i].tick, vecs[i].run, 1'b0);
            if (phase_done) done_pulses++;
            check_out($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_lamps, vecs[i].exp_done);
        end
        check("done_pulses", done_pulses, 3);

        // Tick held high for three cycles counts three times.
        do_reset();
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b1, 1'b0);
        check_out("held_tick", RED_D - 3, L_R, 0);

        // Asynchronous reset mid-YELLOW at count 2, no clock edge needed.
        do_reset();
        for (int i = 0; i < RED_D + GREEN_D + 1; i++) apply(1'b1, 1'b1, 1'b0);
        check_out("pre_async", 2, L_Y, 0);
        #2 rst_n = 1'b0;
        #1 check_out("async_rst", RED_D, L_R, 0);
        tick = 1'b1; run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_out("rst_over_tick", RED_D, L_R, 0);
        tick = 1'b0;
        rst_n = 1'b1;
        model_reset();

`ifdef TRAFFIC_PED_REQ_EN
        // Pedestrian request in GREEN at count 18 clamps to the ceiling.
        do_reset();
        for (int i = 0; i < RED_D + 2; i++) apply(1'b1, 1'b1, 1'b0);
        check_out("ped_pre", 18, L_G, 0);
        apply(1'b0, 1'b1, 1'b1);
        apply(1'b1, 1'b1, 1'b0);
        check_out("ped_clamp", PED_MAX, L_G, 0);
        for (int k = PED_MAX - 1; k >= 1; k--) apply(1'b1, 1'b1, 1'b0);
        check_out("ped_one", 1, L_G, 0);
        apply(1'b1, 1'b1, 1'b0);
        check_out("ped_yellow", YEL_D, L_Y, 1);
`endif

        // Randomized stimulus against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic t, r, p;
            t = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 4) != 0);
            p = PED_EN && ($urandom_range(0, 19) == 0);
            apply(t, r, p);
            model_step(t, r, p);
            check_out($sformatf("rand%0d", i), m_rem, lamps_of(m_phase), m_done);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
